mandelbrot_iter_engine: RTL
===========================

MANDELBROT_ITER_ENGINE -- requirements
Module: mandelbrot_iter_engine

Interface
REQ-001 Parameter WORD_LEN, default 32, width of signed fixed-point c/z values.
REQ-002 Parameter FRAC_BITS, default 28, number of fractional bits.
REQ-003 Parameter ITER_W, default 16, width of the iteration counter and limit.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start_valid  input  1  a job is offered on c_real/c_imag/max_iter.
REQ-007 start_ready  output  1  engine can accept a job.
REQ-008 c_real, c_imag  input  WORD_LEN  signed Q(WORD_LEN-FRAC_BITS).FRAC_BITS point c.
REQ-009 max_iter  input  ITER_W  iteration limit, unsigned.
REQ-010 abort  input  1  synchronous job cancel.
REQ-011 result_valid  output  1  result fields are valid.
REQ-012 result_ready  input  1  consumer accepts the result.
REQ-013 result_count  output  ITER_W  iterations completed.
REQ-014 result_escaped  output  1  1 = point left the bound, 0 = limit reached.

Function
REQ-015 FSM states: IDLE, ITER, DONE; start_ready=1 only in IDLE; result_valid=1 only in DONE.
REQ-016 IDLE: start_valid&&start_ready at an edge latches c and max_iter, sets z=0 and count=0, and moves to ITER.
REQ-017 ITER, one check per edge: mag = zr^2+zi^2 at full 2*WORD_LEN+2-bit precision, compared against 4<<(2*FRAC_BITS) with no truncation.
REQ-018 Escape when mag > bound (strict): go to DONE with escaped=1 and count unchanged; mag equal to the bound does not escape.
REQ-019 Limit: if not escaped and count==max_iter, go to DONE with escaped=0.
REQ-020 Otherwise z_next = (zr^2 - zi^2 + c_real, 2*zr*zi + c_imag) and count increments by 1.
REQ-021 Product rule: full signed products, arithmetic-shifted right by FRAC_BITS, truncated to WORD_LEN; results are defined only for |c_real| and |c_imag| < 4.0.
REQ-022 Latency: result_valid is asserted (result_count+1) cycles after the accept edge.
REQ-023 max_iter=0: one ITER cycle, then result count=0, escaped=0.
REQ-024 DONE: result fields stay stable while result_valid=1 and result_ready=0; result_valid&&result_ready at an edge returns the FSM to IDLE.
REQ-025 Back-to-back jobs: the first start is accepted no earlier than the edge after the DONE->IDLE transition.
REQ-026 abort=1 in ITER: go to IDLE at the next edge with no result; abort is ignored in IDLE and DONE.
REQ-027 Simultaneous abort and escape/limit in ITER: abort wins.

Reset
REQ-028 rst_n low, asynchronously: state=IDLE, z=0, count=0, result_count=0, result_escaped=0, result_valid=0, start_ready=1 once rst_n is released.
REQ-029 Reset mid-ITER or mid-DONE discards the job; no result appears after release.

Configuration
REQ-030 Macro MANDEL_PIPE_EN.
- Defined: a register stage holds zr^2, zi^2 and zr*zi, so each check takes 2 cycles and latency is 2*(result_count+1).
- Not defined: single-cycle checks per REQ-022.
REQ-031 Results are bit-identical with and without MANDEL_PIPE_EN.
REQ-032 With MANDEL_PIPE_EN, abort takes effect at the next edge in either sub-cycle.

Verification (defaults, 1.0 = 0x10000000)
REQ-033 c=(0,0), max_iter=100 -> count=100, escaped=0, result_valid 101 cycles after accept (202 with MANDEL_PIPE_EN).
REQ-034 c=(0x10000000,0x10000000), max_iter=50 -> count=2, escaped=1 (z1=(1,1), mag 2; z2=(1,3), mag 10).
REQ-035 c=(0x20000000,0), max_iter=50 -> mag exactly 4 at count=1 does not escape; count=2, escaped=1.
REQ-036 c=(0xF0000000,0), max_iter=50 -> z oscillates 0/-1; count=50, escaped=0; result_ready held low 10 cycles -> fields stable, start_ready=0 throughout.
REQ-037 c=(0,0), max_iter=1000, abort pulsed 20 cycles after accept -> IDLE next edge, no result_valid, next job c=(0x10000000,0x10000000) -> count=2.
REQ-038 rst_n low for 1 cycle mid-ITER, asynchronous to clk -> outputs at reset values immediately, no result; max_iter=0 job afterwards -> count=0, escaped=0.

Source files
------------

// File: rtl/mandelbrot_iter_engine.sv
// ---------------------------------------------------------------------------
// mandelbrot_iter_engine
//
// Purpose:
//   Iterates z <- z^2 + c from z = 0 for one point c of the complex plane and
//   reports how many iterations ran before |z|^2 exceeded 4, or that the
//   iteration limit was reached first. Values are signed fixed point with
//   FRAC_BITS fractional bits. The engine handles one job at a time through a
//   valid/ready handshake on the job side and another on the result side.
//
// Parameters:
//   WORD_LEN   width of the signed fixed-point c and z values
//   FRAC_BITS  number of fractional bits in c and z
//   ITER_W     width of the iteration counter and the iteration limit
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   start_valid_i     a job is offered on c_real_i / c_imag_i / max_iter_i
//   start_ready_o     engine is idle and can accept a job
//   c_real_i          real part of c
//   c_imag_i          imaginary part of c
//   max_iter_i        iteration limit, unsigned
//   abort_i           cancels the running job, no result is produced
//   result_valid_o    result_count_o / result_escaped_o are valid
//   result_ready_i    consumer accepts the result
//   result_count_o    iterations completed
//   result_escaped_o  1 = point left the bound, 0 = limit reached
//
// Configuration macro:
//   MANDEL_PIPE_EN    when defined, the three squares/products are registered
//                     before the escape decision, so each check takes two
//                     cycles. Results are identical in both builds.
// ---------------------------------------------------------------------------
module mandelbrot_iter_engine #(
    parameter int WORD_LEN  = 32,
    parameter int FRAC_BITS = 28,
    parameter int ITER_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid_i,
    output logic                start_ready_o,
    input  logic [WORD_LEN-1:0] c_real_i,
    input  logic [WORD_LEN-1:0] c_imag_i,
    input  logic [ITER_W-1:0]   max_iter_i,
    input  logic                abort_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ITER_W-1:0]   result_count_o,
    output logic                result_escaped_o
);

    localparam int PW = 2 * WORD_LEN;
    localparam int MW = 2 * WORD_LEN + 2;

    // |z|^2 > 4.0 means escape; 4.0 in the squared domain carries 2*FRAC_BITS
    // fractional bits.
    localparam logic [MW-1:0] BOUND = MW'(4) << (2 * FRAC_BITS);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_e;

    state_e                     state_q, state_d;
    logic signed [WORD_LEN-1:0] cr_q, cr_d;
    logic signed [WORD_LEN-1:0] ci_q, ci_d;
    logic signed [WORD_LEN-1:0] zr_q, zr_d;
    logic signed [WORD_LEN-1:0] zi_q, zi_d;
    logic [ITER_W-1:0]          max_q, max_d;
    logic [ITER_W-1:0]          cnt_q, cnt_d;
    logic                       esc_q, esc_d;

    // Full-precision products of the current z.
    logic signed [PW-1:0] zr2_c, zi2_c, zrzi_c;

    // Products actually used for the decision and the z update.
    logic signed [PW-1:0] zr2, zi2, zrzi;

    // High on the cycle in which the escape/limit decision is taken.
    logic step_en;

    logic [MW-1:0]              mag;
    logic                       escape;
    logic signed [WORD_LEN-1:0] zr_next, zi_next;

    assign zr2_c  = PW'(zr_q) * PW'(zr_q);
    assign zi2_c  = PW'(zi_q) * PW'(zi_q);
    assign zrzi_c = PW'(zr_q) * PW'(zi_q);

`ifdef MANDEL_PIPE_EN
    logic                 phase_q, phase_d;
    logic signed [PW-1:0] zr2_q, zi2_q, zrzi_q;

    // Phase 0 captures the products of the current z, phase 1 decides using
    // them. z only changes at the end of phase 1, so the captured products
    // always belong to the z being checked.
    always_comb begin
        phase_d = 1'b0;
        if (state_q == ITER && !abort_i) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            zr2_q   <= '0;
            zi2_q   <= '0;
            zrzi_q  <= '0;
        end else begin
            phase_q <= phase_d;
            zr2_q   <= zr2_c;
            zi2_q   <= zi2_c;
            zrzi_q  <= zrzi_c;
        end
    end

    assign zr2     = zr2_q;
    assign zi2     = zi2_q;
    assign zrzi    = zrzi_q;
    assign step_en = phase_q;
`else
    assign zr2     = zr2_c;
    assign zi2     = zi2_c;
    assign zrzi    = zrzi_c;
    assign step_en = 1'b1;
`endif

    // Squares are never negative, so zero-extending them keeps the sum exact.
    assign mag    = {2'b00, zr2} + {2'b00, zi2};
    assign escape = (mag > BOUND);

    // Each product is rescaled on its own before being combined; the cross
    // term is doubled after rescaling.
    assign zr_next = WORD_LEN'(zr2 >>> FRAC_BITS) - WORD_LEN'(zi2 >>> FRAC_BITS) + cr_q;
    assign zi_next = (WORD_LEN'(zrzi >>> FRAC_BITS) <<< 1) + ci_q;

    always_comb begin
        state_d = state_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        esc_d   = esc_q;

        case (state_q)
            IDLE: begin
                if (start_valid_i) begin
                    cr_d    = c_real_i;
                    ci_d    = c_imag_i;
                    max_d   = max_iter_i;
                    zr_d    = '0;
                    zi_d    = '0;
                    cnt_d   = '0;
                    esc_d   = 1'b0;
                    state_d = ITER;
                end
            end

            ITER: begin
                // Abort takes priority over a simultaneous escape or limit.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (step_en) begin
                    if (escape) begin
                        esc_d   = 1'b1;
                        state_d = DONE;
                    end else if (cnt_q == max_q) begin
                        esc_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        zr_d  = zr_next;
                        zi_d  = zi_next;
                        cnt_d = cnt_q + ITER_W'(1);
                    end
                end
            end

            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cr_q    <= '0;
            ci_q    <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
            esc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            esc_q   <= esc_d;
        end
    end

    assign start_ready_o    = (state_q == IDLE);
    assign result_valid_o   = (state_q == DONE);
    assign result_count_o   = cnt_q;
    assign result_escaped_o = esc_q;

endmodule
